// File: rtl/riscv_alu_if.sv
// Operand/select/result bundle between the execute stage and the ALU.
interface riscv_alu_if;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  funct3;
  logic        funct7;
  logic [31:0] rd;
  logic        z;

  // Issuing side: presents operands and selects, observes the registered result.
  modport master (
    output rs1, rs2, funct3, funct7,
    input  rd, z
  );

  // ALU side: consumes operands and selects, drives the registered result.
  modport slave (
    input  rs1, rs2, funct3, funct7,
    output rd, z
  );
endinterface

// File: rtl/riscv_alu.sv
// Registered RV32I register-register ALU: one-cycle latency, result plus zero flag.
module riscv_alu (
  input  logic        clk,
  input  logic        rst,
  riscv_alu_if.slave  bus
);

  typedef enum logic [2:0] {
    F3_ADDSUB = 3'b000,
    F3_SLL    = 3'b001,
    F3_SLT    = 3'b010,
    F3_SLTU   = 3'b011,
    F3_XOR    = 3'b100,
    F3_SR     = 3'b101,
    F3_OR     = 3'b110,
    F3_AND    = 3'b111
  } funct3_e;

  logic [31:0] rd_q, rd_d;
  logic        z_q, z_d;
  logic [4:0]  shamt;
  funct3_e     op;

  assign shamt = bus.rs2[4:0];
  assign op    = funct3_e'(bus.funct3);

  // Combinational operation decode and evaluation.
  always_comb begin
    rd_d = '0;
    unique case (op)
      F3_ADDSUB: rd_d = bus.funct7 ? (bus.rs1 - bus.rs2) : (bus.rs1 + bus.rs2);
      F3_SLL:    rd_d = bus.rs1 << shamt;
      F3_SLT:    rd_d = {31'b0, ($signed(bus.rs1) < $signed(bus.rs2))};
      F3_SLTU:   rd_d = {31'b0, (bus.rs1 < bus.rs2)};
      F3_XOR:    rd_d = bus.rs1 ^ bus.rs2;
      F3_SR:     rd_d = bus.funct7 ? 32'($signed(bus.rs1) >>> shamt) : (bus.rs1 >> shamt);
      F3_OR:     rd_d = bus.rs1 | bus.rs2;
      F3_AND:    rd_d = bus.rs1 & bus.rs2;
      default:   rd_d = '0;
    endcase
    z_d = (rd_d == '0);
  end

  // Result and zero-flag registers; reset leaves a clean zero result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      z_q  <= 1'b1;
    end else begin
      rd_q <= rd_d;
      z_q  <= z_d;
    end
  end

  assign bus.rd = rd_q;
  assign bus.z  = z_q;

endmodule

// File: tb/tb_riscv_alu.sv
// Directed-vector bench for riscv_alu.
module tb_riscv_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;

  riscv_alu_if bus ();

  riscv_alu u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] exp_rd;
    logic        exp_z;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3, input logic f7);
    bus.rs1    = a;
    bus.rs2    = b;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  task automatic check(input string name, input logic [31:0] exp_rd, input logic exp_z);
    n_checks++;
    if (bus.rd !== exp_rd || bus.z !== exp_z) begin
      n_fail++;
      $display("FAIL %s: rd=%08h z=%b, expected rd=%08h z=%b",
               name, bus.rd, bus.z, exp_rd, exp_z);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input string n, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f3, input logic f7, input logic [31:0] e);
    vec_t v;
    v.name = n; v.rs1 = a; v.rs2 = b; v.f3 = f3; v.f7 = f7;
    v.exp_rd = e; v.exp_z = (e == 32'h0);
    vecs.push_back(v);
  endtask

  initial begin
    // Add/sub, zero flag
    addv("add_20_30",    32'd20, 32'd30, 3'b000, 1'b0, 32'd50);
    addv("sub_8_3",      32'd8,  32'd3,  3'b000, 1'b1, 32'd5);
    addv("sub_3_8",      32'd3,  32'd8,  3'b000, 1'b1, 32'hFFFF_FFFB);
    addv("sub_eq_zero",  32'd20, 32'd20, 3'b000, 1'b1, 32'd0);
    addv("and_after_z",  32'd20, 32'd30, 3'b111, 1'b0, 32'd20);
    addv("add_ovf",      32'h7FFF_FFFF, 32'd1, 3'b000, 1'b0, 32'h8000_0000);
    // Shifts
    addv("sll_8_3",      32'd8,  32'd3,  3'b001, 1'b0, 32'd64);
    addv("srl_8_3",      32'd8,  32'd3,  3'b101, 1'b0, 32'd1);
    addv("sra_8_3",      32'd8,  32'd3,  3'b101, 1'b1, 32'd1);
    addv("srl_msb_24",   32'h8000_0000, 32'h0000_0024, 3'b101, 1'b0, 32'h0800_0000);
    addv("sra_msb_24",   32'h8000_0000, 32'h0000_0024, 3'b101, 1'b1, 32'hF800_0000);
    addv("sll_amt0",     32'hDEAD_BEEF, 32'hFFFF_FFE0, 3'b001, 1'b0, 32'hDEAD_BEEF);
    addv("sra_amt31",    32'h8000_0000, 32'd31, 3'b101, 1'b1, 32'hFFFF_FFFF);
    addv("sll_out",      32'h8000_0000, 32'd1,  3'b001, 1'b1, 32'h0000_0000);
    // Compares
    addv("slt_8_3",      32'd8,  32'd3,  3'b010, 1'b0, 32'd0);
    addv("sltu_8_3",     32'd8,  32'd3,  3'b011, 1'b0, 32'd0);
    addv("slt_m1_1",     32'hFFFF_FFFF, 32'd1, 3'b010, 1'b0, 32'd1);
    addv("sltu_m1_1",    32'hFFFF_FFFF, 32'd1, 3'b011, 1'b0, 32'd0);
    addv("slt_3_8",      32'd3,  32'd8,  3'b010, 1'b0, 32'd1);
    addv("sltu_3_8",     32'd3,  32'd8,  3'b011, 1'b1, 32'd1);
    // Logic, funct7 ignored
    addv("xor_8_3",      32'd8,  32'd3,  3'b100, 1'b0, 32'd11);
    addv("or_f7",        32'd20, 32'd30, 3'b110, 1'b1, 32'd30);
    addv("and_f7",       32'd20, 32'd30, 3'b111, 1'b1, 32'd20);
    addv("xor_self",     32'hA5A5_5A5A, 32'hA5A5_5A5A, 3'b100, 1'b1, 32'd0);

    // Reset: two edges held with a wrapping ADD presented
    rst = 1'b1;
    drive(32'hFFFF_FFFF, 32'd1, 3'b000, 1'b0);
    step();
    check("reset_edge1", 32'd0, 1'b1);
    step();
    check("reset_edge2", 32'd0, 1'b1);
    rst = 1'b0;
    step();
    check("post_reset_wrap_add", 32'd0, 1'b1);

    // Table, issued back-to-back every cycle
    foreach (vecs[i]) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7);
      step();
      check(vecs[i].name, vecs[i].exp_rd, vecs[i].exp_z);
    end

    // Hold: with inputs unchanged and no new edge, result stays put
    drive(32'd1, 32'd1, 3'b000, 1'b0);
    #3;
    check("hold_between_edges", 32'd0, 1'b1);
    step();
    check("after_hold_add", 32'd2, 1'b0);

    // Mid-stream reset discards the in-flight op; first result on first rst=0 edge
    drive(32'd100, 32'd5, 3'b000, 1'b0);
    rst = 1'b1;
    step();
    check("midstream_reset", 32'd0, 1'b1);
    rst = 1'b0;
    drive(32'd7, 32'd9, 3'b110, 1'b0);
    step();
    check("first_after_midreset", 32'd15, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_alu.md
Name: riscv_alu

Overview:
- Registered 32-bit integer ALU implementing the RV32I register-register operations (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
- Operation select comes straight from the instruction's funct3 field plus a single funct7 modifier bit (instruction bit 30).
- Sits in the execute stage. Result and zero flag are registered, so both are visible one clock after the operands and selects are presented.

Parameters:
- None. Datapath width fixed at 32 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- rs1  input  32  operand A
- rs2  input  32  operand B; for shifts only rs2[4:0] is used
- funct3  input  3  operation select (RV32I funct3 encoding)
- funct7  input  1  modifier bit: 1 selects SUB (with funct3=000) or SRA (with funct3=101)
- rd  output  32  registered result
- z  output  1  registered zero flag; 1 when the registered rd equals 0

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst); the polarity and synchronicity are fixed.
- On a rising clk edge with rst=1: rd <= 0 and z <= 1. Inputs are ignored during that cycle.
- On a rising clk edge with rst=0: rd <= f(rs1, rs2, funct3, funct7), and z <= (f(...) == 0).
- Latency is exactly 1 cycle. There is no handshake. A new operation may be issued every cycle, and rd/z hold until the next edge.
- Operation decode:
  - 000, funct7=0: ADD, rd = rs1 + rs2, modulo 2^32, carry discarded.
  - 000, funct7=1: SUB, rd = rs1 - rs2, modulo 2^32, borrow discarded.
  - 001: SLL, rd = rs1 << rs2[4:0], zeros shifted in.
  - 010: SLT, rd = 1 if signed(rs1) < signed(rs2), else 0. Upper 31 bits are 0.
  - 011: SLTU, rd = 1 if unsigned(rs1) < unsigned(rs2), else 0.
  - 100: XOR, rd = rs1 ^ rs2.
  - 101, funct7=0: SRL, logical right shift by rs2[4:0], zeros shifted in.
  - 101, funct7=1: SRA, arithmetic right shift by rs2[4:0], rs1[31] replicated into vacated bits.
  - 110: OR, rd = rs1 | rs2.
  - 111: AND, rd = rs1 & rs2.
- funct7 is ignored for funct3 values 001, 010, 011, 100, 110 and 111.
- Shift amount 0 passes rs1 unchanged. rs2[31:5] never affects any shift.
- Overflow on ADD/SUB is not flagged. Only the zero flag exists; no carry, negative or overflow outputs.
- z always corresponds to the rd value registered on the same edge, for every operation including compares and logic ops.
- Reset asserted mid-stream discards the in-flight computation. The first post-reset result appears on the first edge with rst=0.
- No X propagation on rd/z after reset, regardless of input values.

Test Plan:
- Reset: hold rst=1 for 2 edges with rs1=0xFFFFFFFF, rs2=1, funct3=000 -> rd=0, z=1. Release rst; after 1 edge rd=0x00000000 (wraparound ADD), z=1.
- Add/sub: rs1=20, rs2=30, funct3=000, funct7=0 -> after 1 edge rd=50, z=0. Then rs1=8, rs2=3, funct7=1 -> rd=5. Then rs1=3, rs2=8, funct7=1 -> rd=0xFFFFFFFB.
- Zero flag: funct3=000, funct7=1, rs1=rs2=20 -> rd=0, z=1. Next cycle funct3=111, rs1=20, rs2=30 -> rd=20, z=0.
- Shifts:
  - rs1=8, rs2=3: SLL -> 64; SRL -> 1; SRA -> 1.
  - rs1=0x80000000, rs2=0x00000024 (amount 4): SRL -> 0x08000000; SRA -> 0xF8000000.
- Compares:
  - rs1=8, rs2=3: SLT -> 0; SLTU -> 0.
  - rs1=0xFFFFFFFF, rs2=1: SLT -> 1; SLTU -> 0.
  - rs1=3, rs2=8: SLT -> 1; SLTU -> 1.
- Logic: rs1=8, rs2=3 XOR -> 11. rs1=20, rs2=30 with funct7=1: OR -> 30, AND -> 20, confirming funct7 is ignored. Back-to-back issue every cycle returns each result exactly one edge later.
